if_fetch_unit: RTL and testbench

- Instruction-fetch stage: the producer side of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/ready handshake. Buffers one fetched instruction with its PC+4.
- Drives the IF/ID register's pc_plus4/inst data, write enable and flush inputs.
- Inserts NOP bubbles when no instruction is ready, and squashes fetches on branch/jump redirect.

---
 rtl/if_fetch_unit.sv | 126 ++++++++++++
 tb/tb_if_fetch_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over req/ready, feeds the IF/ID register.
// Latency: with zero-wait memory, a request in cycle N is buffered at N+1 and loaded into IF/ID at the end of N+1.
// Backpressure: stall holds IF/ID and blocks new fetches while the single-entry buffer is full; requests hold until ready.
module if_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       IF_ID_pc_plus4_in,
    output logic [31:0]       IF_ID_inst_in,
    output logic              IF_ID_write,
    output logic              flush
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // no request outstanding; new fetch comes from r_pc
        S_PEND = 2'd1,  // request to r_req_addr outstanding, data wanted
        S_DROP = 2'd2   // request to r_req_addr outstanding, data squashed by a redirect
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [31:0]         r_buf_inst;
    logic [ADDR_W-1:0]   r_buf_pc4;
    logic                r_buf_valid;

    logic                w_consume;
    logic                w_idle_req;
    logic                w_req;
    logic [ADDR_W-1:0]   w_pc_plus4;
    logic [ADDR_W-1:0]   w_req_plus4;

    // IF/ID takes the buffered instruction only when neither held nor squashed.
    assign w_consume   = r_buf_valid & ~stall & ~redirect;
    // From IDLE a fetch starts whenever the buffer will have room at the clock edge.
    assign w_idle_req  = ~redirect & (~r_buf_valid | w_consume);
    assign w_req       = (r_state != S_IDLE) | w_idle_req;
    // Address arithmetic wraps naturally at ADDR_W bits.
    assign w_pc_plus4  = r_pc + ADDR_W'(4);
    assign w_req_plus4 = r_req_addr + ADDR_W'(4);

    // Reset is folded in combinationally so the outputs reach their reset values without a clock.
    assign imem_req    = rst & w_req;
    assign imem_addr   = (r_state == S_IDLE) ? r_pc : r_req_addr;
    assign IF_ID_write = rst & w_consume;
    // A redirect flushes even under stall; flush always dominates the write.
    assign flush       = ~rst | redirect | (~r_buf_valid & ~stall);
    assign IF_ID_inst_in = r_buf_inst;

    generate
        if (ADDR_W >= 32) begin : g_pc4_trunc
            assign IF_ID_pc_plus4_in = r_buf_pc4[31:0];
        end else begin : g_pc4_ext
            assign IF_ID_pc_plus4_in = {{(32 - ADDR_W){1'b0}}, r_buf_pc4};
        end
    endgenerate

    // Fetch state machine: PC, outstanding request tracking and the one-entry instruction buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_req_addr  <= '0;
            r_buf_inst  <= '0;
            r_buf_pc4   <= '0;
            r_buf_valid <= 1'b0;
        end else if (redirect) begin
            // Redirect wins over everything: retarget, drop the buffer, and squash
            // any outstanding request by waiting out its ready in DROP.
            r_pc        <= redirect_pc;
            r_buf_valid <= 1'b0;
            if ((r_state != S_IDLE) && !imem_ready) begin
                r_state <= S_DROP;
            end else begin
                r_state <= S_IDLE;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_idle_req && imem_ready) begin
                        r_buf_inst  <= imem_rdata;
                        r_buf_pc4   <= w_pc_plus4;
                        r_buf_valid <= 1'b1;
                        r_pc        <= w_pc_plus4;
                    end else begin
                        r_buf_valid <= r_buf_valid & ~w_consume;
                        if (w_idle_req) begin
                            r_req_addr <= r_pc;
                            r_state    <= S_PEND;
                        end
                    end
                end
                S_PEND: begin
                    if (imem_ready) begin
                        r_buf_inst  <= imem_rdata;
                        r_buf_pc4   <= w_req_plus4;
                        r_buf_valid <= 1'b1;
                        r_pc        <= w_req_plus4;
                        r_state     <= S_IDLE;
                    end else begin
                        r_buf_valid <= r_buf_valid & ~w_consume;
                    end
                end
                S_DROP: begin
                    // r_pc already holds the redirect target; just retire the stale request.
                    if (imem_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model with configurable or random wait states,
// and a queue-based reference of the instruction stream that IF/ID should see.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc_plus4_in;
    logic [31:0] IF_ID_inst_in;
    logic        IF_ID_write;
    logic        flush;

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .IF_ID_pc_plus4_in (IF_ID_pc_plus4_in),
        .IF_ID_inst_in     (IF_ID_inst_in),
        .IF_ID_write       (IF_ID_write),
        .flush             (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    // Reference model: instructions fetched in program order and not yet handed to IF/ID.
    ent_t        q[$];
    logic [31:0] exp_fetch;
    bit          drop_pending;
    bit          outstanding;
    logic [31:0] out_addr;

    // Memory model state
    int          wait_cfg;
    int          mem_wait_left;
    bit          rand_wait;

    // Samples taken just before each rising edge
    logic        s_req, s_ready, s_write, s_flush;
    logic [31:0] s_addr, s_pc4, s_inst;

    int n_checks = 0;
    int n_fail   = 0;

    // One clock cycle: memory responds, outputs are checked against the model, model advances.
    task automatic step();
        bit exp_write, exp_flush, exp_req, done;
        #1;
        if (imem_req && mem_wait_left == 0) begin
            imem_ready = 1'b1;
            imem_rdata = imem_addr | 32'h1;
        end else begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
        end
        #1;
        s_req = imem_req; s_ready = imem_ready; s_addr = imem_addr;
        s_write = IF_ID_write; s_flush = flush;
        s_pc4 = IF_ID_pc_plus4_in; s_inst = IF_ID_inst_in;

        exp_write = (q.size() != 0) && !stall && !redirect;
        exp_flush = redirect || ((q.size() == 0) && !stall);
        n_checks++;
        if (s_write !== exp_write) begin
            n_fail++; $display("FAIL write: got %b expected %b at %0t", s_write, exp_write, $time);
        end
        n_checks++;
        if (s_flush !== exp_flush) begin
            n_fail++; $display("FAIL flush: got %b expected %b at %0t", s_flush, exp_flush, $time);
        end
        if (outstanding) begin
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== out_addr) begin
                n_fail++; $display("FAIL hold: got req=%b addr=%h expected req=1 addr=%h at %0t", s_req, s_addr, out_addr, $time);
            end
        end else begin
            exp_req = !redirect && ((q.size() == 0) || exp_write);
            n_checks++;
            if (s_req !== exp_req) begin
                n_fail++; $display("FAIL req: got %b expected %b at %0t", s_req, exp_req, $time);
            end
        end
        if (q.size() != 0) begin
            n_checks++;
            if (s_pc4 !== q[0].pc4 || s_inst !== q[0].inst) begin
                n_fail++; $display("FAIL ifid_data: got pc4=%h inst=%h expected pc4=%h inst=%h at %0t", s_pc4, s_inst, q[0].pc4, q[0].inst, $time);
            end
        end

        if (exp_write) void'(q.pop_front());
        done = s_req && s_ready;
        if (redirect) begin
            q.delete();
            exp_fetch    = redirect_pc;
            drop_pending = s_req && !s_ready;
        end else if (done) begin
            if (drop_pending) begin
                drop_pending = 1'b0;
            end else begin
                n_checks++;
                if (s_addr !== exp_fetch) begin
                    n_fail++; $display("FAIL fetch_addr: got %h expected %h at %0t", s_addr, exp_fetch, $time);
                end
                q.push_back('{pc4: exp_fetch + 32'd4, inst: exp_fetch | 32'h1});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        outstanding = s_req && !s_ready;
        out_addr    = s_addr;

        if (done) mem_wait_left = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
        else if (s_req) mem_wait_left--;

        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        exp_fetch = RESET_PC; drop_pending = 1'b0; outstanding = 1'b0;
        rand_wait = 1'b0; mem_wait_left = wait_cfg;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rdata = '0;
        #3;
        n_checks++;
        if (imem_req !== 1'b0 || flush !== 1'b1 || IF_ID_write !== 1'b0 ||
            IF_ID_inst_in !== 32'h0 || IF_ID_pc_plus4_in !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got req=%b flush=%b write=%b inst=%h pc4=%h expected 0 1 0 0 0",
                               imem_req, flush, IF_ID_write, IF_ID_inst_in, IF_ID_pc_plus4_in);
        end
    endtask

    task automatic test_zero_wait();
        wait_cfg = 0; apply_reset();
        step();
        n_checks++;
        if (s_flush !== 1'b1 || s_write !== 1'b0 || s_req !== 1'b1 || s_addr !== RESET_PC) begin
            n_fail++; $display("FAIL zw_first: got flush=%b write=%b req=%b addr=%h expected 1 0 1 %h", s_flush, s_write, s_req, s_addr, RESET_PC);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (s_write !== 1'b1 || s_pc4 !== 32'(4 * k) || s_inst !== 32'(4 * (k - 1) + 1) || s_addr !== 32'(4 * k)) begin
                n_fail++; $display("FAIL zw_seq%0d: got write=%b pc4=%h inst=%h addr=%h expected 1 %h %h %h",
                                   k, s_write, s_pc4, s_inst, s_addr, 32'(4 * k), 32'(4 * (k - 1) + 1), 32'(4 * k));
            end
        end
    endtask

    task automatic test_wait_states();
        bit exp_w;
        wait_cfg = 2; apply_reset();
        for (int c = 0; c < 12; c++) begin
            step();
            exp_w = (c > 0) && (c % 3 == 0);
            n_checks++;
            if (s_addr !== 32'(4 * (c / 3)) || s_write !== exp_w || s_flush !== !exp_w ||
                (exp_w && s_pc4 !== 32'(4 * (c / 3)))) begin
                n_fail++; $display("FAIL wait_c%0d: got addr=%h write=%b flush=%b pc4=%h expected addr=%h write=%b",
                                   c, s_addr, s_write, s_flush, s_pc4, 32'(4 * (c / 3)), exp_w);
            end
        end
        wait_cfg = 0;
    endtask

    task automatic test_stall();
        wait_cfg = 0; apply_reset();
        repeat (3) step();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (s_write !== 1'b0 || s_flush !== 1'b0 || s_req !== 1'b0 || s_pc4 !== 32'd12 || s_inst !== 32'd9) begin
                n_fail++; $display("FAIL stall_c%0d: got write=%b flush=%b req=%b pc4=%h inst=%h expected 0 0 0 c 9",
                                   c, s_write, s_flush, s_req, s_pc4, s_inst);
            end
        end
        stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (s_write !== 1'b1 || s_pc4 !== 32'(12 + 4 * k) || s_inst !== 32'(9 + 4 * k)) begin
                n_fail++; $display("FAIL stall_resume%0d: got write=%b pc4=%h inst=%h expected 1 %h %h",
                                   k, s_write, s_pc4, s_inst, 32'(12 + 4 * k), 32'(9 + 4 * k));
            end
        end
    endtask

    task automatic test_redirect_pend();
        wait_cfg = 0; apply_reset();
        step(); step();
        mem_wait_left = 3;
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h8 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL rp_pend: got req=%b addr=%h ready=%b expected 1 8 0", s_req, s_addr, s_ready);
        end
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        n_checks++;
        if (s_flush !== 1'b1 || s_write !== 1'b0 || s_addr !== 32'h8) begin
            n_fail++; $display("FAIL rp_redirect: got flush=%b write=%b addr=%h expected 1 0 8", s_flush, s_write, s_addr);
        end
        redirect = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h8 || s_write !== 1'b0 || s_ready !== (c == 1)) begin
                n_fail++; $display("FAIL rp_drop%0d: got req=%b addr=%h write=%b ready=%b expected 1 8 0 %b",
                                   c, s_req, s_addr, s_write, s_ready, (c == 1));
            end
        end
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 || s_write !== 1'b0) begin
            n_fail++; $display("FAIL rp_target: got req=%b addr=%h write=%b expected 1 100 0", s_req, s_addr, s_write);
        end
        step();
        n_checks++;
        if (s_write !== 1'b1 || s_pc4 !== 32'h104 || s_inst !== 32'h101) begin
            n_fail++; $display("FAIL rp_load: got write=%b pc4=%h inst=%h expected 1 104 101", s_write, s_pc4, s_inst);
        end
    endtask

    task automatic test_redirect_stall();
        wait_cfg = 0; apply_reset();
        step(); step();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        n_checks++;
        if (s_flush !== 1'b1 || s_write !== 1'b0 || s_req !== 1'b0) begin
            n_fail++; $display("FAIL rs_cycle: got flush=%b write=%b req=%b expected 1 0 0", s_flush, s_write, s_req);
        end
        stall = 1'b0; redirect = 1'b0;
        step();
        n_checks++;
        if (s_addr !== 32'h200 || s_req !== 1'b1 || s_flush !== 1'b1) begin
            n_fail++; $display("FAIL rs_next: got addr=%h req=%b flush=%b expected 200 1 1", s_addr, s_req, s_flush);
        end
        step();
        n_checks++;
        if (s_write !== 1'b1 || s_pc4 !== 32'h204 || s_inst !== 32'h201) begin
            n_fail++; $display("FAIL rs_load: got write=%b pc4=%h inst=%h expected 1 204 201", s_write, s_pc4, s_inst);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc4 [3];
        logic [31:0] exp_ins [3];
        exp_pc4[0] = 32'hFFFF_FFFC; exp_ins[0] = 32'hFFFF_FFF9;
        exp_pc4[1] = 32'h0000_0000; exp_ins[1] = 32'hFFFF_FFFD;
        exp_pc4[2] = 32'h0000_0004; exp_ins[2] = 32'h0000_0001;
        wait_cfg = 0; apply_reset();
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        step();
        n_checks++;
        if (s_addr !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL wrap_target: got addr=%h expected fffffff8", s_addr);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (s_write !== 1'b1 || s_pc4 !== exp_pc4[k] || s_inst !== exp_ins[k]) begin
                n_fail++; $display("FAIL wrap%0d: got write=%b pc4=%h inst=%h expected 1 %h %h",
                                   k, s_write, s_pc4, s_inst, exp_pc4[k], exp_ins[k]);
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        wait_cfg = 0; apply_reset();
        step(); step();
        mem_wait_left = 5;
        step(); step();
        n_checks++;
        if (imem_req !== 1'b1 || IF_ID_inst_in === 32'h0) begin
            n_fail++; $display("FAIL rm_pre: got req=%b inst=%h expected req=1 with nonzero inst", imem_req, IF_ID_inst_in);
        end
        #3;
        rst = 1'b0; stall = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || flush !== 1'b1 || IF_ID_write !== 1'b0 ||
            IF_ID_inst_in !== 32'h0 || IF_ID_pc_plus4_in !== 32'h0) begin
            n_fail++; $display("FAIL rm_async: got req=%b flush=%b write=%b inst=%h pc4=%h expected 0 1 0 0 0",
                               imem_req, flush, IF_ID_write, IF_ID_inst_in, IF_ID_pc_plus4_in);
        end
        apply_reset();
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
            n_fail++; $display("FAIL rm_first: got req=%b addr=%h expected 1 %h", s_req, s_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        int writes = 0;
        wait_cfg = 0; apply_reset();
        rand_wait = 1'b1; mem_wait_left = $urandom_range(0, 3);
        for (int c = 0; c < 600; c++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            step();
            if (s_write) writes++;
        end
        stall = 1'b0; redirect = 1'b0; rand_wait = 1'b0;
        n_checks++;
        if (writes < 50) begin
            n_fail++; $display("FAIL rand_progress: got %0d IF/ID writes expected at least 50", writes);
        end
    endtask

    initial begin
        wait_cfg = 0; rand_wait = 1'b0; mem_wait_left = 0;
        q.delete(); exp_fetch = RESET_PC; drop_pending = 1'b0; outstanding = 1'b0; out_addr = '0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_pend();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_pend();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
